core_alu_rmw_seq: RTL and testbench

//  Sequences 6502-style read-modify-write memory instructions (ASL/LSR/ROL/ROR/INC/DEC abs).
//  Per accepted request it runs bus read -> dummy write of original -> write of result.
//  It drives the shared core ALU with core_alu_ctl control words and captures result and flags.

---
 rtl/core_alu_rmw_seq_if.sv | 54 +++++
 rtl/core_alu_rmw_seq.sv | 174 +++++++++++++++++
 tb/tb_core_alu_rmw_seq.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_alu_rmw_seq_if.sv
// Request, bus, ALU and completion signals of the RMW sequencer.
// master = sequencer side, slave = decoder/bus/ALU environment side.
interface core_alu_rmw_seq_if #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int ALU_CTL_W = 17
);
  logic                 req_valid;
  logic                 req_ready;
  logic [2:0]           req_op;
  logic [ADDR_W-1:0]    req_addr;
  logic                 req_carry;

  logic [ADDR_W-1:0]    bus_addr;
  logic                 bus_rd;
  logic                 bus_wr;
  logic [DATA_W-1:0]    bus_wdata;
  logic [DATA_W-1:0]    bus_rdata;
  logic                 bus_rdy;

  logic [ALU_CTL_W-1:0] alu_ctl;
  logic [DATA_W-1:0]    alu_lhs;
  logic [DATA_W-1:0]    alu_rhs;
  logic                 alu_carry;
  logic [DATA_W-1:0]    alu_result;
  logic                 alu_carry_out;
  logic                 alu_zero;
  logic                 alu_sign;

  logic                 done_valid;
  logic [DATA_W-1:0]    done_result;
  logic [2:0]           done_flags;
  logic                 done_err;

  modport master (
    input  req_valid, req_op, req_addr, req_carry,
    input  bus_rdata, bus_rdy,
    input  alu_result, alu_carry_out, alu_zero, alu_sign,
    output req_ready,
    output bus_addr, bus_rd, bus_wr, bus_wdata,
    output alu_ctl, alu_lhs, alu_rhs, alu_carry,
    output done_valid, done_result, done_flags, done_err
  );

  modport slave (
    output req_valid, req_op, req_addr, req_carry,
    output bus_rdata, bus_rdy,
    output alu_result, alu_carry_out, alu_zero, alu_sign,
    input  req_ready,
    input  bus_addr, bus_rd, bus_wr, bus_wdata,
    input  alu_ctl, alu_lhs, alu_rhs, alu_carry,
    input  done_valid, done_result, done_flags, done_err
  );
endinterface

// File: rtl/core_alu_rmw_seq.sv
// 6502-style read-modify-write sequencer: read, dummy write of original, write of ALU result.
// All outputs are registered from the next state; the ALU wait overlaps the dummy write.
module core_alu_rmw_seq #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int ALU_CTL_W = 17,
  parameter int ALU_LAT   = 1
) (
  input  logic              clock,
  input  logic              reset,
  core_alu_rmw_seq_if.master bus_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DUMMY,
    S_WAIT_ALU,
    S_WRITE,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [2:0]           r_op;
  logic                 r_carry;
  logic [DATA_W-1:0]    r_res;
  logic [2:0]           r_flags;
  logic                 r_res_valid;
  logic                 r_alu_busy;
  logic [2:0]           r_lat_cnt;

  logic                 r_req_ready;
  logic [ADDR_W-1:0]    r_bus_addr;
  logic                 r_bus_rd;
  logic                 r_bus_wr;
  logic [DATA_W-1:0]    r_bus_wdata;
  logic [ALU_CTL_W-1:0] r_alu_ctl;
  logic [DATA_W-1:0]    r_alu_opnd;
  logic                 r_alu_carry;
  logic                 r_done_valid;
  logic [DATA_W-1:0]    r_done_result;
  logic [2:0]           r_done_flags;
  logic                 r_done_err;

  logic                 w_accept;
  logic                 w_legal;
  logic                 w_alu_fire;
  logic                 w_res_ready;
  logic                 w_incdec;
  logic [ALU_CTL_W-1:0] w_ctl;

  assign w_accept    = (r_state == S_IDLE) && r_req_ready && bus_if.req_valid;
  assign w_legal     = (bus_if.req_op <= 3'd5);
  assign w_alu_fire  = r_alu_busy && (r_lat_cnt == 3'(ALU_LAT));
  assign w_res_ready = r_res_valid || w_alu_fire;
  assign w_incdec    = (r_op == 3'd4) || (r_op == 3'd5);

  always_comb begin
    w_ctl = '0;
    case (r_op)
      3'd0:    w_ctl = ALU_CTL_W'(17'h00646);
      3'd1:    w_ctl = ALU_CTL_W'(17'h00A46);
      3'd2:    w_ctl = ALU_CTL_W'(17'h00606);
      3'd3:    w_ctl = ALU_CTL_W'(17'h00A06);
      3'd4:    w_ctl = ALU_CTL_W'(17'h0016E);
      3'd5:    w_ctl = ALU_CTL_W'(17'h00176);
      default: w_ctl = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_state_nxt = w_legal ? S_READ : S_DONE;
      S_READ:     if (bus_if.bus_rdy) w_state_nxt = S_DUMMY;
      S_DUMMY:    if (bus_if.bus_rdy) w_state_nxt = w_res_ready ? S_WRITE : S_WAIT_ALU;
      S_WAIT_ALU: if (w_res_ready) w_state_nxt = S_WRITE;
      S_WRITE:    if (bus_if.bus_rdy) w_state_nxt = S_DONE;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_carry       <= 1'b0;
      r_res         <= '0;
      r_flags       <= '0;
      r_res_valid   <= 1'b0;
      r_alu_busy    <= 1'b0;
      r_lat_cnt     <= '0;
      r_req_ready   <= 1'b0;
      r_bus_addr    <= '0;
      r_bus_rd      <= 1'b0;
      r_bus_wr      <= 1'b0;
      r_bus_wdata   <= '0;
      r_alu_ctl     <= '0;
      r_alu_opnd    <= '0;
      r_alu_carry   <= 1'b0;
      r_done_valid  <= 1'b0;
      r_done_result <= '0;
      r_done_flags  <= '0;
      r_done_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_bus_rd     <= (w_state_nxt == S_READ);
      r_bus_wr     <= (w_state_nxt == S_DUMMY) || (w_state_nxt == S_WRITE);
      r_done_valid <= (w_state_nxt == S_DONE);

      if (w_accept) begin
        r_op    <= bus_if.req_op;
        r_carry <= bus_if.req_carry;
        if (w_legal) begin
          r_bus_addr <= bus_if.req_addr;
        end else begin
          r_done_err    <= 1'b1;
          r_done_result <= '0;
          r_done_flags  <= '0;
        end
      end

      // The ALU is launched on the read-completion edge so its latency overlaps the dummy write.
      if (r_state == S_READ && bus_if.bus_rdy) begin
        r_bus_wdata <= bus_if.bus_rdata;
        r_alu_opnd  <= bus_if.bus_rdata;
        r_alu_ctl   <= w_ctl;
        r_alu_carry <= r_carry;
        r_alu_busy  <= 1'b1;
        r_lat_cnt   <= 3'd1;
        r_res_valid <= 1'b0;
      end

      if (w_alu_fire) begin
        r_alu_ctl   <= '0;
        r_alu_busy  <= 1'b0;
        r_res_valid <= 1'b1;
        r_res       <= bus_if.alu_result;
        r_flags     <= {bus_if.alu_sign, bus_if.alu_zero,
                        w_incdec ? r_carry : bus_if.alu_carry_out};
      end else if (r_alu_busy) begin
        r_lat_cnt <= r_lat_cnt + 3'd1;
      end

      if (w_state_nxt == S_WRITE && r_state != S_WRITE)
        r_bus_wdata <= w_alu_fire ? bus_if.alu_result : r_res;

      if (r_state == S_WRITE && bus_if.bus_rdy) begin
        r_done_err    <= 1'b0;
        r_done_result <= r_res;
        r_done_flags  <= r_flags;
      end
    end
  end

  assign bus_if.req_ready   = r_req_ready;
  assign bus_if.bus_addr    = r_bus_addr;
  assign bus_if.bus_rd      = r_bus_rd;
  assign bus_if.bus_wr      = r_bus_wr;
  assign bus_if.bus_wdata   = r_bus_wdata;
  assign bus_if.alu_ctl     = r_alu_ctl;
  assign bus_if.alu_lhs     = r_alu_opnd;
  assign bus_if.alu_rhs     = r_alu_opnd;
  assign bus_if.alu_carry   = r_alu_carry;
  assign bus_if.done_valid  = r_done_valid;
  assign bus_if.done_result = r_done_result;
  assign bus_if.done_flags  = r_done_flags;
  assign bus_if.done_err    = r_done_err;

endmodule

// File: tb/tb_core_alu_rmw_seq.sv
// Bench for core_alu_rmw_seq: ALU_LAT=1 and ALU_LAT=3 instances on shared stimulus,
// a latency-aware behavioural ALU per instance, and an arithmetic reference model.
module tb_core_alu_rmw_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [15:0] req_addr;
  logic        req_carry;
  logic [7:0]  bus_rdata;
  logic        bus_rdy;
  logic        sel;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  core_alu_rmw_seq_if #(.DATA_W(8), .ADDR_W(16), .ALU_CTL_W(17)) if1 ();
  core_alu_rmw_seq_if #(.DATA_W(8), .ADDR_W(16), .ALU_CTL_W(17)) if3 ();

  core_alu_rmw_seq #(.DATA_W(8), .ADDR_W(16), .ALU_CTL_W(17), .ALU_LAT(1)) dut1 (
    .clock(clock), .reset(reset), .bus_if(if1.master));
  core_alu_rmw_seq #(.DATA_W(8), .ADDR_W(16), .ALU_CTL_W(17), .ALU_LAT(3)) dut3 (
    .clock(clock), .reset(reset), .bus_if(if3.master));

  assign if1.req_valid = req_valid;  assign if3.req_valid = req_valid;
  assign if1.req_op    = req_op;     assign if3.req_op    = req_op;
  assign if1.req_addr  = req_addr;   assign if3.req_addr  = req_addr;
  assign if1.req_carry = req_carry;  assign if3.req_carry = req_carry;
  assign if1.bus_rdata = bus_rdata;  assign if3.bus_rdata = bus_rdata;
  assign if1.bus_rdy   = bus_rdy;    assign if3.bus_rdy   = bus_rdy;

  // Behavioural ALU: outputs are corrupted until the control word has been held ALU_LAT cycles.
  function automatic logic [10:0] alu_f(input logic [16:0] ctl, input logic [7:0] a,
                                        input logic ci, input logic ok);
    logic [8:0] w;
    case (ctl)
      17'h00646: w = {a, 1'b0};
      17'h00A46: w = {a[0], 1'b0, a[7:1]};
      17'h00606: w = {a, ci};
      17'h00A06: w = {a[0], ci, a[7:1]};
      17'h0016E: w = {1'b0, a} + 9'd1;
      17'h00176: w = {1'b0, a} - 9'd1;
      default:   w = '0;
    endcase
    return {ok ? w[7:0] : (w[7:0] ^ 8'h5A), w[8] ^ !ok, (w[7:0] == 8'h00) ^ !ok, w[7] ^ !ok};
  endfunction

  int h1 = 0;
  int h3 = 0;
  always @(negedge clock) begin
    h1 <= (if1.alu_ctl != '0) ? h1 + 1 : 0;
    h3 <= (if3.alu_ctl != '0) ? h3 + 1 : 0;
  end
  assign {if1.alu_result, if1.alu_carry_out, if1.alu_zero, if1.alu_sign} =
    alu_f(if1.alu_ctl, if1.alu_lhs, if1.alu_carry, h1 >= 1);
  assign {if3.alu_result, if3.alu_carry_out, if3.alu_zero, if3.alu_sign} =
    alu_f(if3.alu_ctl, if3.alu_lhs, if3.alu_carry, h3 >= 3);

  logic        m_req_ready, m_bus_rd, m_bus_wr, m_alu_carry, m_done_valid, m_done_err;
  logic [15:0] m_bus_addr;
  logic [7:0]  m_bus_wdata, m_alu_lhs, m_alu_rhs, m_done_result;
  logic [16:0] m_alu_ctl;
  logic [2:0]  m_done_flags;
  assign m_req_ready   = sel ? if3.req_ready   : if1.req_ready;
  assign m_bus_rd      = sel ? if3.bus_rd      : if1.bus_rd;
  assign m_bus_wr      = sel ? if3.bus_wr      : if1.bus_wr;
  assign m_bus_addr    = sel ? if3.bus_addr    : if1.bus_addr;
  assign m_bus_wdata   = sel ? if3.bus_wdata   : if1.bus_wdata;
  assign m_alu_ctl     = sel ? if3.alu_ctl     : if1.alu_ctl;
  assign m_alu_lhs     = sel ? if3.alu_lhs     : if1.alu_lhs;
  assign m_alu_rhs     = sel ? if3.alu_rhs     : if1.alu_rhs;
  assign m_alu_carry   = sel ? if3.alu_carry   : if1.alu_carry;
  assign m_done_valid  = sel ? if3.done_valid  : if1.done_valid;
  assign m_done_result = sel ? if3.done_result : if1.done_result;
  assign m_done_flags  = sel ? if3.done_flags  : if1.done_flags;
  assign m_done_err    = sel ? if3.done_err    : if1.done_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] ctl_of(input logic [2:0] op);
    case (op)
      3'd0:    return 17'h00646;
      3'd1:    return 17'h00A46;
      3'd2:    return 17'h00606;
      3'd3:    return 17'h00A06;
      3'd4:    return 17'h0016E;
      3'd5:    return 17'h00176;
      default: return 17'h0;
    endcase
  endfunction

  // Reference model from the instruction definitions: returns {err, N, Z, C, result}.
  function automatic logic [11:0] ref_model(input logic [2:0] op, input logic [7:0] d, input logic c);
    int v, r, cf;
    v = int'(d);
    cf = int'(c);
    case (op)
      3'd0: begin r = (v * 2) % 256;       cf = v / 128; end
      3'd1: begin r = v / 2;               cf = v % 2;   end
      3'd2: begin r = (v * 2 + cf) % 256;  cf = v / 128; end
      3'd3: begin r = v / 2 + cf * 128;    cf = v % 2;   end
      3'd4: r = (v + 1) % 256;
      3'd5: r = (v + 255) % 256;
      default: return {1'b1, 3'b000, 8'h00};
    endcase
    return {1'b0, r >= 128, r == 0, cf != 0, 8'(r)};
  endfunction

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } ev_t;
  ev_t tr[$];

  task automatic do_op(input string tag, input logic l3, input logic [2:0] op, input logic [15:0] addr,
                       input logic [7:0] data, input logic c, input int rdy_pct,
                       input logic [7:0] eres, input logic [2:0] eflags, input logic eerr, input int ecyc);
    bit acc;
    int ndone, done_cyc;
    logic prev_act, prev_rdy, prev_rd, prev_wr, seen_wr;
    logic [15:0] prev_addr;
    logic [7:0] prev_wd;
    sel = l3;
    tr.delete();
    @(negedge clock);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_carry = c;
    bus_rdy = 1'b1; bus_rdata = data;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_req_ready) begin acc = 1; break; end
      @(negedge clock);
    end
    check({tag, "_accept"}, 32'(acc), 32'd1);
    if (!acc) begin req_valid = 1'b0; return; end
    @(negedge clock);
    req_valid = 1'b0;
    ndone = 0; done_cyc = 0; prev_act = 0; prev_rdy = 1; prev_rd = 0; prev_wr = 0;
    prev_addr = '0; prev_wd = '0; seen_wr = 0;
    for (int cyc = 1; cyc <= 300 && ndone == 0; cyc++) begin
      bus_rdy = (rdy_pct < 0) ? !(cyc inside {[1:3], [6:8]})
                              : (int'($urandom_range(99)) < rdy_pct);
      bus_rdata = bus_rdy ? data : ~data;
      if (prev_act && !prev_rdy)
        check({tag, "_stall_stable"}, {6'd0, m_bus_rd, m_bus_wr, m_bus_addr, m_bus_wdata},
              {6'd0, prev_rd, prev_wr, prev_addr, prev_wd});
      if (m_bus_wr && !seen_wr) begin
        seen_wr = 1;
        check({tag, "_dummy_ctl"}, 32'(m_alu_ctl), 32'(ctl_of(op)));
        check({tag, "_dummy_opnd"}, {7'd0, m_alu_carry, m_alu_lhs, m_alu_rhs}, {7'd0, c, data, data});
      end
      if ((m_bus_rd || m_bus_wr) && bus_rdy)
        tr.push_back('{m_bus_wr, m_bus_addr, m_bus_wr ? m_bus_wdata : data, cyc});
      if (m_done_valid) begin
        ndone = 1;
        done_cyc = cyc;
        check({tag, "_done"}, {m_done_err, m_done_flags, m_done_result}, {eerr, eflags, eres});
        check({tag, "_ctl_nop"}, 32'(m_alu_ctl), 32'd0);
      end
      prev_act = m_bus_rd || m_bus_wr; prev_rdy = bus_rdy;
      prev_rd = m_bus_rd; prev_wr = m_bus_wr; prev_addr = m_bus_addr; prev_wd = m_bus_wdata;
      @(negedge clock);
    end
    check({tag, "_done_seen"}, 32'(ndone), 32'd1);
    if (ndone == 1) begin
      check({tag, "_after_done"}, {m_done_valid, m_req_ready, m_done_result},
            {1'b0, 1'b1, eres});
      if (ecyc > 0) check({tag, "_latency"}, 32'(done_cyc), 32'(ecyc));
    end
    check({tag, "_nbus"}, 32'(tr.size()), eerr ? 32'd0 : 32'd3);
    if (!eerr && tr.size() == 3) begin
      check({tag, "_rd"},  {15'd0, tr[0].wr, tr[0].addr}, {15'd0, 1'b0, addr});
      check({tag, "_dwr"}, {7'd0, tr[1].wr, tr[1].addr, tr[1].data}, {7'd0, 1'b1, addr, data});
      check({tag, "_wr"},  {7'd0, tr[2].wr, tr[2].addr, tr[2].data}, {7'd0, 1'b1, addr, eres});
      if (rdy_pct == 100 && ecyc > 0)
        check({tag, "_bus_cycles"}, {tr[0].cyc[7:0], tr[1].cyc[7:0], tr[2].cyc[7:0]},
              {8'd1, 8'd2, 8'(ecyc - 1)});
    end
    bus_rdy = 1'b1; bus_rdata = data;
    repeat (8) @(negedge clock);
  endtask

  typedef struct {
    bit          lat3;
    logic [2:0]  op;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        c;
    int          rdy_pct;
    logic [7:0]  res;
    logic [2:0]  flags;
    logic        err;
    int          cycles;
  } vec_t;
  vec_t vecs[13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] m;
    logic [2:0]  rop;
    logic [7:0]  rdat;
    logic        rc, rl3;
    int          pct, ecyc, ndone, nstrobe;

    //             lat3 op    addr      data   c     rdy  res    NZC     err   cyc
    vecs[0]  = '{0, 3'd0, 16'h0200, 8'h81, 1'b0, 100, 8'h02, 3'b001, 1'b0, 4};
    vecs[1]  = '{0, 3'd3, 16'h0300, 8'h01, 1'b1, 100, 8'h80, 3'b101, 1'b0, 4};
    vecs[2]  = '{0, 3'd5, 16'h0400, 8'h01, 1'b1, 100, 8'h00, 3'b011, 1'b0, 4};
    vecs[3]  = '{0, 3'd1, 16'h1234, 8'h01, 1'b0, 100, 8'h00, 3'b011, 1'b0, 4};
    vecs[4]  = '{0, 3'd2, 16'hFFFF, 8'hC0, 1'b1, 100, 8'h81, 3'b101, 1'b0, 4};
    vecs[5]  = '{0, 3'd4, 16'h0000, 8'h7F, 1'b0, 100, 8'h80, 3'b100, 1'b0, 4};
    vecs[6]  = '{0, 3'd4, 16'h0ABC, 8'hFF, 1'b0, 100, 8'h00, 3'b010, 1'b0, 4};
    vecs[7]  = '{1, 3'd4, 16'h0200, 8'hFF, 1'b1, 100, 8'h00, 3'b011, 1'b0, 6};
    vecs[8]  = '{0, 3'd0, 16'h0300, 8'h40, 1'b0, -1,  8'h80, 3'b100, 1'b0, 10};
    vecs[9]  = '{0, 3'd7, 16'h0500, 8'h55, 1'b0, 100, 8'h00, 3'b000, 1'b1, 1};
    vecs[10] = '{1, 3'd6, 16'h0600, 8'hAA, 1'b1, 100, 8'h00, 3'b000, 1'b1, 1};
    vecs[11] = '{1, 3'd3, 16'h0700, 8'h00, 1'b0, -1,  8'h00, 3'b010, 1'b0, 10};
    vecs[12] = '{1, 3'd5, 16'h8000, 8'h00, 1'b0, 100, 8'hFF, 3'b100, 1'b0, 6};

    sel = 1'b0; reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0;
    req_carry = 1'b0; bus_rdy = 1'b1; bus_rdata = '0;
    repeat (2) @(negedge clock);
    check("reset_ctrl", {m_req_ready, m_bus_rd, m_bus_wr, m_done_valid, m_done_err, m_alu_carry},
          6'b000000);
    check("reset_bus", {m_bus_addr, m_bus_wdata}, 24'h0);
    check("reset_alu", {m_alu_ctl, m_alu_lhs, m_alu_rhs}, 33'h0);
    check("reset_done", {m_done_flags, m_done_result}, 11'h0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", 32'(m_req_ready), 32'd1);

    for (int i = 0; i < 13; i++)
      do_op($sformatf("vec%0d", i), vecs[i].lat3, vecs[i].op, vecs[i].addr, vecs[i].data,
            vecs[i].c, vecs[i].rdy_pct, vecs[i].res, vecs[i].flags, vecs[i].err, vecs[i].cycles);

    // Reset while the dummy write is on the bus.
    sel = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_op = 3'd0; req_addr = 16'h0555; req_carry = 1'b0;
    bus_rdy = 1'b1; bus_rdata = 8'h42;
    @(negedge clock);
    req_valid = 1'b0;
    check("rst_mid_read", 32'(m_bus_rd), 32'd1);
    @(negedge clock);
    check("rst_mid_dummy", {m_bus_wr, m_bus_wdata}, {1'b1, 8'h42});
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_ctrl", {m_req_ready, m_bus_rd, m_bus_wr, m_done_valid}, 4'b0000);
    check("rst_mid_vals", {m_bus_addr, m_bus_wdata, m_alu_ctl, m_done_result}, 49'h0);
    reset = 1'b0;
    ndone = 0; nstrobe = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (m_done_valid) ndone++;
      if (m_bus_rd || m_bus_wr) nstrobe++;
    end
    check("rst_mid_no_done", 32'(ndone), 32'd0);
    check("rst_mid_no_strobe", 32'(nstrobe), 32'd0);
    check("rst_mid_ready", 32'(m_req_ready), 32'd1);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(7));
      rdat = 8'($urandom);
      rc = 1'($urandom_range(1));
      rl3 = 1'($urandom_range(1));
      pct = ($urandom_range(1) == 1) ? 100 : 50;
      m = ref_model(rop, rdat, rc);
      ecyc = (pct != 100) ? -1 : (m[11] ? 1 : (rl3 ? 6 : 4));
      do_op($sformatf("rnd%0d", i), rl3, rop, 16'($urandom), rdat, rc, pct,
            m[7:0], m[10:8], m[11], ecyc);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
